// File: rtl/step_counter_sel_if.sv
// rtl/step_counter_sel_if.sv - control/data bundle for step_counter_sel
// master drives controls and values; slave (the counter) returns count, out_val, wrap.
interface step_counter_sel_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             sel_in;
   logic [WIDTH-1:0] in_val;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] out_val;
   logic             wrap;

   modport master (
      output en, up_dn, load, load_val, sel_in, in_val,
      input  count, out_val, wrap
   );

   modport slave (
      input  en, up_dn, load, load_val, sel_in, in_val,
      output count, out_val, wrap
   );
endinterface

// File: rtl/step_counter_sel.sv
// rtl/step_counter_sel.sv - up/down step counter with load, registered output mux, wrap pulse
// Optional STEP_COUNTER_SAT_EN: saturate at 0 / 2**WIDTH-1 instead of wrapping.
module step_counter_sel #(
   parameter int WIDTH   = 4,
   parameter int STEP    = 1,
   parameter int RST_VAL = 0
) (
   input logic              clk,
   input logic              rst_n,
   step_counter_sel_if.slave bus
);
   localparam logic [WIDTH-1:0] RST_V  = RST_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];

   generate
      if (STEP < 1 || STEP >= (2 ** WIDTH)) begin : g_bad_step
         $error("step_counter_sel: STEP must be in 1..2**WIDTH-1");
      end
   endgenerate

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] out_val_q;
   logic             wrap_q;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   diff_dn;

   // The extra top bit of each result is the carry (up) or borrow (down).
   assign sum_up  = {1'b0, count_q} + {1'b0, STEP_W};
   assign diff_dn = {1'b0, count_q} - {1'b0, STEP_W};

   always_comb begin
      count_nxt = count_q;
      wrap_nxt  = 1'b0;
      if (bus.load) begin
         count_nxt = bus.load_val;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            wrap_nxt = sum_up[WIDTH];
`ifdef STEP_COUNTER_SAT_EN
            count_nxt = sum_up[WIDTH] ? {WIDTH{1'b1}} : sum_up[WIDTH-1:0];
`else
            count_nxt = sum_up[WIDTH-1:0];
`endif
         end else begin
            wrap_nxt = diff_dn[WIDTH];
`ifdef STEP_COUNTER_SAT_EN
            count_nxt = diff_dn[WIDTH] ? {WIDTH{1'b0}} : diff_dn[WIDTH-1:0];
`else
            count_nxt = diff_dn[WIDTH-1:0];
`endif
         end
      end
   end

   // out_val tracks the value count takes on this same edge, so it never lags count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q   <= RST_V;
         out_val_q <= RST_V;
         wrap_q    <= 1'b0;
      end else begin
         count_q   <= count_nxt;
         wrap_q    <= wrap_nxt;
         out_val_q <= bus.sel_in ? bus.in_val : count_nxt;
      end
   end

   assign bus.count   = count_q;
   assign bus.out_val = out_val_q;
   assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_step_counter_sel.sv
// tb/tb_step_counter_sel.sv - directed self-checking bench for step_counter_sel
// Two instances: STEP=1 (dut_a) and STEP=3 (dut_b), both WIDTH=4, RST_VAL=3.
module tb_step_counter_sel;
   localparam int WIDTH = 4;
`ifdef STEP_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   step_counter_sel_if #(.WIDTH(WIDTH)) if_a ();
   step_counter_sel_if #(.WIDTH(WIDTH)) if_b ();

   step_counter_sel #(.WIDTH(WIDTH), .STEP(1), .RST_VAL(3)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a.slave)
   );

   step_counter_sel #(.WIDTH(WIDTH), .STEP(3), .RST_VAL(3)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int c, input int o, input int w);
      check({tag, ".count"},   int'(if_a.count),   c);
      check({tag, ".out_val"}, int'(if_a.out_val), o);
      check({tag, ".wrap"},    int'(if_a.wrap),    w);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      if_a.en = 1'b1; if_a.up_dn = 1'b1; if_a.load = 1'b0; if_a.load_val = '0;
      if_a.sel_in = 1'b0; if_a.in_val = '0;
      if_b.en = 1'b1; if_b.up_dn = 1'b0; if_b.load = 1'b0; if_b.load_val = '0;
      if_b.sel_in = 1'b0; if_b.in_val = '0;

      // reset held for two edges with en high
      tick();
      check_a("rst1", 3, 3, 0);
      check("rst1.b_count", int'(if_b.count), 3);
      tick();
      check_a("rst2", 3, 3, 0);
      check("rst2.b_wrap", int'(if_b.wrap), 0);

      // up wrap, STEP=1
      rst_n = 1'b1;
      if_b.en = 1'b0;
      if_a.en = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd14;
      tick();
      check_a("load14", 14, 14, 0);
      if_a.load = 1'b0; if_a.en = 1'b1; if_a.up_dn = 1'b1;
      tick();
      check_a("up1", 15, 15, 0);
      tick();
      check_a("up2", SAT ? 15 : 0, SAT ? 15 : 0, 1);
      tick();
      check_a("up3", SAT ? 15 : 1, SAT ? 15 : 1, SAT ? 1 : 0);

      // down, STEP=3
      if_b.load = 1'b1; if_b.load_val = 4'd2;
      tick();
      check("b_load2", int'(if_b.count), 2);
      if_b.load = 1'b0; if_b.en = 1'b1; if_b.up_dn = 1'b0;
      tick();
      check("b_dn1.count", int'(if_b.count), SAT ? 0 : 15);
      check("b_dn1.wrap",  int'(if_b.wrap), 1);
      tick();
      check("b_dn2.count", int'(if_b.count), SAT ? 0 : 12);
      check("b_dn2.wrap",  int'(if_b.wrap), SAT ? 1 : 0);
      check("b_dn2.out",   int'(if_b.out_val), SAT ? 0 : 12);
      if_b.en = 1'b0;

      // load beats en
      if_a.load = 1'b1; if_a.load_val = 4'd9; if_a.en = 1'b1; if_a.up_dn = 1'b1;
      tick();
      check_a("prio_load", 9, 9, 0);
      // reset beats load
      rst_n = 1'b0; if_a.load_val = 4'd5;
      tick();
      check_a("prio_rst", 3, 3, 0);

      // reset on an edge that would otherwise wrap
      rst_n = 1'b1; if_a.load_val = 4'd15;
      tick();
      check("pre_wrap.count", int'(if_a.count), 15);
      if_a.load = 1'b0; if_a.en = 1'b1; if_a.up_dn = 1'b1; rst_n = 1'b0;
      tick();
      check_a("rst_mid", 3, 3, 0);
      rst_n = 1'b1;

      // output mux
      if_a.sel_in = 1'b1; if_a.in_val = 4'hA;
      tick();
      check_a("mux_in", 4, 10, 0);
      if_a.sel_in = 1'b0;
      tick();
      check_a("mux_cnt", 5, 5, 0);

      // hold with en low
      if_a.load = 1'b1; if_a.load_val = 4'd7;
      tick();
      check_a("load7", 7, 7, 0);
      if_a.load = 1'b0; if_a.en = 1'b0; if_a.in_val = 4'h2;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_a($sformatf("hold%0d", i), 7, 7, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
